// File: rtl/instr_loader.sv
// Boot-time program loader: receives a framed byte stream, packs it into
// 32-bit instruction words, writes them to instruction memory from byte
// address 0x0, and holds the CPU in reset until a checksum-verified program
// is resident.
module instr_loader #(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int unsigned IDX_W = ADDR_WIDTH + 1;
  localparam int unsigned CAP   = 32'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR0 = 3'd1,
    ST_HDR1 = 3'd2,
    ST_DATA = 3'd3,
    ST_CSUM = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } state_e;

  state_e           r_state;
  state_e           w_state_nxt;

  logic             r_rx_ready;
  logic             r_busy;
  logic             r_cpu_hold;
  logic             r_done;
  logic             r_error;
  logic             w_rx_ready_nxt;
  logic             w_busy_nxt;
  logic             w_cpu_hold_nxt;
  logic             w_done_nxt;
  logic             w_error_nxt;

  logic [7:0]       r_n_hi;
  logic [15:0]      r_n;
  logic [IDX_W-1:0] r_idx;
  logic [1:0]       r_bcnt;
  logic [23:0]      r_asm;
  logic [7:0]       r_xor;
  logic             r_mem_we;
  logic [31:0]      r_mem_addr;
  logic [31:0]      r_mem_wdata;

  logic             w_accept;
  logic             w_start_load;
  logic [15:0]      w_n;
  logic             w_hdr_ovf;
  logic             w_hdr_zero;
  logic [IDX_W-1:0] w_idx_inc;
  logic             w_word_done;
  logic             w_last_word;
  logic             w_csum_ok;

  // Handshake and frame-decode helpers
  always_comb begin
    w_accept     = rx_valid & r_rx_ready;
    w_start_load = start & ((r_state == ST_IDLE) | (r_state == ST_DONE) |
                            (r_state == ST_ERR));
    w_n          = {r_n_hi, rx_data};
    w_hdr_ovf    = 32'(w_n) > CAP;
    w_hdr_zero   = (w_n == 16'd0);
    w_idx_inc    = r_idx + IDX_W'(1);
    w_word_done  = (r_state == ST_DATA) & w_accept & (r_bcnt == 2'd3);
    w_last_word  = 32'(w_idx_inc) == 32'(r_n);
    w_csum_ok    = ((r_xor ^ rx_data) == 8'h00);
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (w_start_load) w_state_nxt = ST_HDR0;
      end
      ST_HDR0: begin
        if (w_accept) w_state_nxt = ST_HDR1;
      end
      ST_HDR1: begin
        if (w_accept) begin
          if (w_hdr_ovf)       w_state_nxt = ST_ERR;
          else if (w_hdr_zero) w_state_nxt = ST_CSUM;
          else                 w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_word_done && w_last_word) w_state_nxt = ST_CSUM;
      end
      ST_CSUM: begin
        if (w_accept) w_state_nxt = w_csum_ok ? ST_DONE : ST_ERR;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the next state, then registered
  always_comb begin
    w_rx_ready_nxt = 1'b0;
    w_busy_nxt     = 1'b0;
    w_cpu_hold_nxt = 1'b1;
    w_done_nxt     = 1'b0;
    w_error_nxt    = 1'b0;
    case (w_state_nxt)
      ST_HDR0, ST_HDR1, ST_DATA, ST_CSUM: begin
        w_rx_ready_nxt = 1'b1;
        w_busy_nxt     = 1'b1;
      end
      ST_DONE: begin
        w_done_nxt     = 1'b1;
        w_cpu_hold_nxt = 1'b0;
      end
      ST_ERR: begin
        w_error_nxt    = 1'b1;
      end
      default: begin
        w_rx_ready_nxt = 1'b0;
      end
    endcase
  end

  // State and status registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_rx_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_cpu_hold <= 1'b1;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rx_ready <= w_rx_ready_nxt;
      r_busy     <= w_busy_nxt;
      r_cpu_hold <= w_cpu_hold_nxt;
      r_done     <= w_done_nxt;
      r_error    <= w_error_nxt;
    end
  end

  // Header capture, word assembly, running XOR and memory write port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_n_hi      <= 8'h00;
      r_n         <= 16'h0000;
      r_idx       <= '0;
      r_bcnt      <= 2'd0;
      r_asm       <= 24'h000000;
      r_xor       <= 8'h00;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'h0000_0000;
      r_mem_wdata <= 32'h0000_0000;
    end else begin
      r_mem_we <= 1'b0;
      if (w_start_load) begin
        r_idx  <= '0;
        r_bcnt <= 2'd0;
        r_xor  <= 8'h00;
      end else if (w_accept) begin
        r_xor <= r_xor ^ rx_data;
        case (r_state)
          ST_HDR0: r_n_hi <= rx_data;
          ST_HDR1: r_n    <= w_n;
          ST_DATA: begin
            r_bcnt <= r_bcnt + 2'd1;
            r_asm  <= {r_asm[15:0], rx_data};
            if (r_bcnt == 2'd3) begin
              r_mem_we    <= 1'b1;
              r_mem_addr  <= 32'({r_idx, 2'b00});
              r_mem_wdata <= {r_asm, rx_data};
              r_idx       <= w_idx_inc;
            end
          end
          default: r_n_hi <= r_n_hi;
        endcase
      end
    end
  end

  assign rx_ready  = r_rx_ready;
  assign busy      = r_busy;
  assign cpu_hold  = r_cpu_hold;
  assign done      = r_done;
  assign error     = r_error;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: loads, checksum failures, empty and
// oversize programs, stalls and asynchronous abort.
module tb_instr_loader;

  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;

  int checks   = 0;
  int failures = 0;

  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];
  logic        wq_hold[$];
  byte_q_t     frame;

  // status vector: {rx_ready, mem_we, busy, done, error, cpu_hold}
  localparam logic [5:0] S_RESET = 6'b000001;
  localparam logic [5:0] S_BUSY  = 6'b101001;
  localparam logic [5:0] S_DONE  = 6'b000100;
  localparam logic [5:0] S_ERR   = 6'b000011;
  localparam logic [5:0] S_WRITE = 6'b111001;

  instr_loader #(.ADDR_WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  // Instruction-memory model: captures every write strobe at the clock edge
  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      wq_addr.push_back(mem_addr);
      wq_data.push_back(mem_wdata);
      wq_hold.push_back(cpu_hold);
    end
  end

  function automatic logic [5:0] status();
    return {rx_ready, mem_we, busy, done, error, cpu_hold};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_writes();
    wq_addr.delete();
    wq_data.delete();
    wq_hold.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present a byte from a falling edge; returns at the falling edge after acceptance
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ready_timeout", 32'(n), 32'(0));
    @(negedge clk);
  endtask

  task automatic send_frame(input byte_q_t q, input bit stall);
    foreach (q[i]) begin
      send_byte(q[i]);
      if (stall) begin
        rx_valid = 1'b0;
        @(negedge clk);
      end
    end
    rx_valid = 1'b0;
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;

    // Reset held with random inputs
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start    = 1'($urandom);
      rx_valid = 1'($urandom);
      rx_data  = 8'($urandom);
    end
    #1;
    chk("rst_status", 32'(status()), 32'(S_RESET));
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);

    @(negedge clk);
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    reset    = 1'b1;
    clear_writes();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_status", 32'(status()), 32'(S_RESET));
    end
    chk("idle_writes", 32'(wq_addr.size()), 32'd0);

    // Nominal two-word load at full rate
    clear_writes();
    pulse_start();
    chk("nom_hdr0_status", 32'(status()), 32'(S_BUSY));
    frame = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h11, 8'h00, 8'hFF, 8'hFF, 8'h3E};
    send_frame(frame, 1'b0);
    chk("nom_status", 32'(status()), 32'(S_DONE));
    chk("nom_nwrites", 32'(wq_addr.size()), 32'd2);
    chk("nom_w0_addr", wq_addr[0], 32'h0000_0000);
    chk("nom_w0_data", wq_data[0], 32'h2008_0005);
    chk("nom_w1_addr", wq_addr[1], 32'h0000_0004);
    chk("nom_w1_data", wq_data[1], 32'h1100_FFFF);
    chk("nom_w1_hold", 32'(wq_hold[1]), 32'd1);

    // Bad checksum: writes still land, load reports error
    clear_writes();
    pulse_start();
    chk("bad_hdr0_status", 32'(status()), 32'(S_BUSY));
    frame = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h11, 8'h00, 8'hFF, 8'hFF, 8'h3F};
    send_frame(frame, 1'b0);
    chk("bad_status", 32'(status()), 32'(S_ERR));
    chk("bad_nwrites", 32'(wq_addr.size()), 32'd2);
    chk("bad_w0_addr", wq_addr[0], 32'h0000_0000);
    chk("bad_w1_data", wq_data[1], 32'h1100_FFFF);

    // Empty program, then empty program with wrong checksum
    clear_writes();
    pulse_start();
    frame = '{8'h00, 8'h00, 8'h00};
    send_frame(frame, 1'b0);
    chk("empty_status", 32'(status()), 32'(S_DONE));
    chk("empty_nwrites", 32'(wq_addr.size()), 32'd0);
    pulse_start();
    chk("restart_status", 32'(status()), 32'(S_BUSY));
    frame = '{8'h00, 8'h00, 8'h01};
    send_frame(frame, 1'b0);
    chk("empty_bad_status", 32'(status()), 32'(S_ERR));
    chk("empty_bad_nwrites", 32'(wq_addr.size()), 32'd0);

    // Oversize word count (257 > 256)
    clear_writes();
    pulse_start();
    frame = '{8'h01, 8'h01};
    send_frame(frame, 1'b0);
    chk("ovf_status", 32'(status()), 32'(S_ERR));
    chk("ovf_nwrites", 32'(wq_addr.size()), 32'd0);

    // Exactly full memory (256 words) is accepted into DATA
    pulse_start();
    frame = '{8'h01, 8'h00};
    send_frame(frame, 1'b0);
    chk("cap_status", 32'(status()), 32'(S_BUSY));
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Nominal frame with rx_valid toggling
    clear_writes();
    pulse_start();
    frame = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h11, 8'h00, 8'hFF, 8'hFF, 8'h3E};
    send_frame(frame, 1'b1);
    chk("stall_status", 32'(status()), 32'(S_DONE));
    chk("stall_nwrites", 32'(wq_addr.size()), 32'd2);
    chk("stall_w0_data", wq_data[0], 32'h2008_0005);
    chk("stall_w1_addr", wq_addr[1], 32'h0000_0004);
    chk("stall_w1_data", wq_data[1], 32'h1100_FFFF);

    // Abort with asynchronous reset while the first write is pending
    clear_writes();
    pulse_start();
    frame = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05};
    foreach (frame[i]) send_byte(frame[i]);
    chk("abort_pre_status", 32'(status()), 32'(S_WRITE));
    chk("abort_pre_wdata", mem_wdata, 32'h2008_0005);
    #1 reset = 1'b0;
    #1;
    chk("abort_status", 32'(status()), 32'(S_RESET));
    chk("abort_addr", mem_addr, 32'h0);
    chk("abort_wdata", mem_wdata, 32'h0);
    rx_valid = 1'b0;
    @(negedge clk);
    chk("abort_nwrites", 32'(wq_addr.size()), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    pulse_start();
    frame = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h11, 8'h00, 8'hFF, 8'hFF, 8'h3E};
    send_frame(frame, 1'b0);
    chk("reload_status", 32'(status()), 32'(S_DONE));
    chk("reload_nwrites", 32'(wq_addr.size()), 32'd2);
    chk("reload_w0_addr", wq_addr[0], 32'h0000_0000);
    chk("reload_w0_data", wq_data[0], 32'h2008_0005);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
